axi4lite_regfile_slave: RTL
===========================

AXI4LITE_REGFILE_SLAVE -- requirements
Module: axi4lite_regfile_slave

Interface
REQ-001 Parameter NREGS, default 16, sets the number of 64-bit registers (1..256).
REQ-002 Parameter BASE_ADDR, default 64'h0, is the byte address of register 0.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port s_mosi, input, crossbar::axi4lite_MOSI_t: the AXI4-Lite request channels from one crossbar slave port.
REQ-006 Port s_miso, output, crossbar::axi4lite_MISO_t: the AXI4-Lite response channels back to that crossbar port.
REQ-007 Port regs_q, output, NREGS x 64 bits: current register contents for local hardware.

Function
REQ-008 The block SHALL be the downstream endpoint of a crossbar slave port and SHALL ignore awprot and arprot.
REQ-009 Decode: offset = addr - BASE_ADDR; an access is valid only if addr >= BASE_ADDR, addr[2:0] == 0 and offset>>3 < NREGS.
REQ-010 AW and W SHALL be accepted independently: awready = 1 while no AW is held and B is idle; wready = 1 while no W is held and B is idle.
REQ-011 A handshake (valid && ready) SHALL latch awaddr or wdata/wstrb; both may be latched in the same cycle.
REQ-012 The write FSM SHALL have states W_IDLE, W_GOT_A, W_GOT_D and W_RESP; W_IDLE goes to W_GOT_A or W_GOT_D on one handshake, or to W_RESP on both.
REQ-013 The write SHALL commit in the cycle the FSM enters W_RESP, updating only the bytes whose wstrb bit is 1; wstrb = 0 still completes with a response.
REQ-014 bvalid SHALL rise one cycle after the second of the AW/W handshakes and hold with a stable bresp until bready; W_RESP then goes to W_IDLE.
REQ-015 bresp uses the package's 1-bit encoding: 0 = OKAY, 1 = SLVERR.
REQ-016 The read FSM SHALL have states R_IDLE (arready = 1) and R_DATA (arready = 0, rvalid = 1).
REQ-017 An AR handshake SHALL capture rdata and rresp at the handshake edge and enter R_DATA, so the read latency is 1 cycle.
REQ-018 rdata and rresp SHALL stay stable until rready; R_DATA then returns to R_IDLE, with no back-to-back AR in the same cycle.
REQ-019 If an AR handshake and a write commit hit the same register in the same cycle, the read SHALL return the pre-write value.
REQ-020 The read and write paths SHALL operate fully concurrently, with at most one outstanding transaction per direction.

Reset
REQ-021 While rst_n = 0, all registers SHALL be 0; both FSMs SHALL be idle with no AW/W held.
REQ-022 Reset values: awready = wready = arready = 1; bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0.
REQ-023 Reset asserted mid-transaction SHALL abort it and any uncommitted write SHALL be lost.

Configuration
REQ-024 With macro REGFILE_ERR_RESP_EN defined, an invalid address (REQ-009) SHALL return bresp/rresp = 1, leave registers unchanged and return rdata = 0.
REQ-025 Without REGFILE_ERR_RESP_EN, an invalid access SHALL return response 0, leave registers unchanged and return rdata = 0.

Structure
REQ-026 Response codes RESP_OKAY = 1'b0 and RESP_SLVERR = 1'b1, and the write/read FSM state enums, SHALL be added to package crossbar.
REQ-027 The address check SHALL be one sub-module, regfile_addr_decode (addr -> hit, index), instantiated once for writes and once for reads.

Verification
REQ-028 AW 0x08 and W 0xDEADBEEF_CAFEF00D, wstrb 0xFF, in the same cycle -> bvalid on the next cycle with bresp 0; a read of 0x08 then returns 0xDEADBEEF_CAFEF00D.
REQ-029 W sent 3 cycles before AW 0x10 with wstrb 0x0F on a register holding 0 -> register = 0x00000000_<low 32 bits of wdata>, bvalid 1 cycle after AW.
REQ-030 bready held 0 for 5 cycles -> bvalid and bresp stable, awready/wready = 0 throughout, and a new AW is accepted only after the B handshake.
REQ-031 With NREGS = 16, read 0x80 and write 0x0C -> response 1 with REGFILE_ERR_RESP_EN, 0 without; registers unchanged and rdata = 0 in both builds.
REQ-032 AR and write commit to 0x18 (old value 5, new value 9) in the same cycle -> rdata = 5; a following read returns 9.
REQ-033 rst_n pulsed low with rvalid = 1 and an AW held -> all outputs at their REQ-022 values immediately, and regs_q all 0.

Source files
------------

// File: rtl/axi4lite_regfile_slave_pkg.sv
// Shared AXI4-Lite crossbar types: channel bundles, 1-bit response codes and
// the register-file slave's write/read FSM state encodings.
package crossbar;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef struct packed {
    logic [63:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        bready;
    logic [63:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } axi4lite_MOSI_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic        bresp;
    logic        bvalid;
    logic        arready;
    logic [63:0] rdata;
    logic        rresp;
    logic        rvalid;
  } axi4lite_MISO_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_GOT_A,
    W_GOT_D,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  // Merge new_val into old_val on the byte lanes enabled by strb.
  function automatic logic [63:0] apply_wstrb(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_regfile_slave_addr_decode.sv
// Byte address to register index decode: 8-byte aligned, at or above the base,
// and inside the register window.
module regfile_addr_decode #(
  parameter int          NREGS     = 16,
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          IDX_W     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic [63:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  logic [63:0] offset;
  logic [63:0] word_idx;

  always_comb begin
    offset   = addr - BASE_ADDR;
    word_idx = offset >> 3;
    hit      = (addr >= BASE_ADDR) && (addr[2:0] == 3'b000) &&
               (word_idx < 64'(NREGS));
    index    = word_idx[IDX_W-1:0];
  end

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register file endpoint of NREGS x 64-bit registers.
// Define REGFILE_ERR_RESP_EN to answer out-of-window accesses with SLVERR.
module axi4lite_regfile_slave
  import crossbar::*;
#(
  parameter int          NREGS     = 16,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  axi4lite_MOSI_t              s_mosi,
  output axi4lite_MISO_t              s_miso,
  output logic [NREGS-1:0][63:0]      regs_q
);

  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
`ifdef REGFILE_ERR_RESP_EN
  localparam logic ERR_RESP = RESP_SLVERR;
`else
  localparam logic ERR_RESP = RESP_OKAY;
`endif

  // Handshake contract: a beat transfers on the rising edge where valid and
  // ready are both high; valid holds its payload stable until that edge.
  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic [63:0]           awaddr_q, awaddr_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [7:0]            wstrb_q, wstrb_d;
  logic                  bresp_q, bresp_d;
  logic [63:0]           rdata_q, rdata_d;
  logic                  rresp_q, rresp_d;
  logic [NREGS-1:0][63:0] regs_d;

  logic                  aw_ready, w_ready, ar_ready;
  logic                  aw_hs, w_hs, commit;
  logic [63:0]           wr_addr, wr_data;
  logic [7:0]            wr_strb;
  logic                  wr_hit, rd_hit;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic                  prot_unused;

  assign prot_unused = ^{s_mosi.awprot, s_mosi.arprot};

  assign aw_ready = (wr_state_q == W_IDLE) || (wr_state_q == W_GOT_D);
  assign w_ready  = (wr_state_q == W_IDLE) || (wr_state_q == W_GOT_A);
  assign ar_ready = (rd_state_q == R_IDLE);
  assign aw_hs    = s_mosi.awvalid && aw_ready;
  assign w_hs     = s_mosi.wvalid && w_ready;

  // The commit may use a beat arriving this cycle, so bypass the holding flops.
  assign wr_addr = aw_hs ? s_mosi.awaddr : awaddr_q;
  assign wr_data = w_hs ? s_mosi.wdata : wdata_q;
  assign wr_strb = w_hs ? s_mosi.wstrb : wstrb_q;

  regfile_addr_decode #(.NREGS(NREGS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_wr_dec (
    .addr  (wr_addr),
    .hit   (wr_hit),
    .index (wr_idx)
  );

  regfile_addr_decode #(.NREGS(NREGS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_rd_dec (
    .addr  (s_mosi.araddr),
    .hit   (rd_hit),
    .index (rd_idx)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    regs_d     = regs_q;
    commit     = 1'b0;

    if (aw_hs) awaddr_d = s_mosi.awaddr;
    if (w_hs) begin
      wdata_d = s_mosi.wdata;
      wstrb_d = s_mosi.wstrb;
    end

    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_d = W_RESP;
          commit     = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = W_GOT_A;
        end else if (w_hs) begin
          wr_state_d = W_GOT_D;
        end
      end
      W_GOT_A: begin
        if (w_hs) begin
          wr_state_d = W_RESP;
          commit     = 1'b1;
        end
      end
      W_GOT_D: begin
        if (aw_hs) begin
          wr_state_d = W_RESP;
          commit     = 1'b1;
        end
      end
      W_RESP: begin
        if (s_mosi.bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase

    if (commit) begin
      bresp_d = wr_hit ? RESP_OKAY : ERR_RESP;
      if (wr_hit) regs_d[wr_idx] = apply_wstrb(regs_q[wr_idx], wr_data, wr_strb);
    end
  end

  // Reads sample regs_q before this edge's commit, so a colliding read sees old data.
  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s_mosi.arvalid) begin
          rd_state_d = R_DATA;
          rdata_d    = rd_hit ? regs_q[rd_idx] : 64'h0;
          rresp_d    = rd_hit ? RESP_OKAY : ERR_RESP;
        end
      end
      R_DATA: begin
        if (s_mosi.rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      regs_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
    end
  end

  always_comb begin
    s_miso         = '0;
    s_miso.awready = aw_ready;
    s_miso.wready  = w_ready;
    s_miso.bvalid  = (wr_state_q == W_RESP);
    s_miso.bresp   = bresp_q;
    s_miso.arready = ar_ready;
    s_miso.rvalid  = (rd_state_q == R_DATA);
    s_miso.rdata   = rdata_q;
    s_miso.rresp   = rresp_q;
  end

endmodule
